// File: rtl/sram_word_controller_pkg.sv
// Shared SRAM interface types and constants for the cache's SRAM path.
package sram_word_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } sram_state_e;

    localparam int SRAM_WAIT_CYCLES = 5;
    localparam int SRAM_DATA_W      = 16;
    localparam int SRAM_ADDR_W      = 18;

endpackage

// File: rtl/sram_word_controller_wait_counter.sv
// Per-phase wait counter: counts 0..WAIT_CYCLES-1, flags the last cycle.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5,
    parameter int CNT_WIDTH   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Clear wins over count so each phase restarts from zero.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (en)
            count_d = count_q + 1'b1;
    end

    // Counter register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign tc = (count_q == CNT_WIDTH'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_word_controller.sv
// Splits one 32-bit word access into two 16-bit SRAM accesses (low, then high).
module sram_word_controller
    import sram_word_controller_pkg::*;
#(
    parameter int WAIT_CYCLES     = SRAM_WAIT_CYCLES,
    parameter int SRAM_ADDR_WIDTH = SRAM_ADDR_W,
    parameter int CNT_WIDTH       = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [31:0]                address,
    input  logic [31:0]                writeData,
    output logic [31:0]                readData,
    output logic                       ready,
    inout  wire  [SRAM_DATA_W-1:0]     SRAM_DQ,
    output logic [SRAM_ADDR_WIDTH-1:0] SRAM_ADDR,
    output logic                       SRAM_UB_N,
    output logic                       SRAM_LB_N,
    output logic                       SRAM_CE_N,
    output logic                       SRAM_WE_N,
    output logic                       SRAM_OE_N
);

    localparam int WA = SRAM_ADDR_WIDTH - 1;  // word address width

    sram_state_e                state_q, state_d;
    logic [WA-1:0]              addr_q, addr_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       is_wr_q, is_wr_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                       we_n_q, we_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       dq_oe_q, dq_oe_d;
    logic [SRAM_DATA_W-1:0]     dq_out_q, dq_out_d;

    logic req;
    logic in_phase;
    logic tc;
    logic half;

    // Byte-address bits outside the half-word address alias away by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{address[31:SRAM_ADDR_WIDTH+1], address[1:0]};

    assign req      = wr_en | rd_en;
    assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (~in_phase | tc),
        .en  (in_phase),
        .tc  (tc)
    );

    // Next state, request latching, read sampling and next bus drive values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_wr_d     = is_wr_q;
        rdata_d     = rdata_q;
        half        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = address[SRAM_ADDR_WIDTH:2];
                    wdata_d = writeData;
                    is_wr_d = wr_en;          // write wins a collision
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tc) begin
                    if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tc) begin
                    if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered from the next state so they line up
        // with the state they belong to; OE_N and the driver are exclusive.
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
            half        = (state_d == ST_HIGH);
            sram_addr_d = {addr_d, half};
            dq_out_d    = half ? wdata_d[31:16] : wdata_d[15:0];
            we_n_d      = ~is_wr_d;
            oe_n_d      = is_wr_d;
            dq_oe_d     = is_wr_d;
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_wr_q     <= is_wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // Idle ready drops combinationally so the cache freezes on the request cycle.
    assign ready = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SRAM_DATA_W{1'bz}};
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign readData  = rdata_q;

endmodule
